jtsdram_rdarb: RTL and testbench

// - Round-robin read arbiter. Lets four checker bank requesters (jtsdram_bank style rd/ack/rdy) share one SDRAM read port.
// - Sits between the jtsdram_bank instances and the SDRAM controller's single read channel.
// - Drives the bank select from the granted requester.
// - Has a watchdog that aborts a stalled transaction and flags it.

---
 rtl/jtsdram_rdarb_pkg.sv | 29 ++
 rtl/jtsdram_rr_pick.sv | 28 ++
 rtl/jtsdram_rdarb.sv | 121 ++++++++++++
 tb/tb_jtsdram_rdarb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtsdram_rdarb_pkg.sv
// Shared definitions for the SDRAM read arbiter: FSM states, requester
// index width and small helpers for requester index arithmetic.
package jtsdram_rdarb_pkg;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned NREQ  = 4;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_t;

  // Next requester in round-robin order (wraps 3 -> 0)
  function automatic idx_t next_idx(input idx_t i);
    return i + 1'b1;
  endfunction

  // One-hot requester mask for a given index
  function automatic logic [NREQ-1:0] onehot(input idx_t i);
    logic [NREQ-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/jtsdram_rr_pick.sv
// Four-way rotating priority encoder: returns the first set request bit
// scanning from prio upwards, modulo 4.
module jtsdram_rr_pick
  import jtsdram_rdarb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] prio,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  idx_t              off;

  // Rotate so that prio sits at bit 0, then take the lowest set bit
  always_comb begin
    dbl   = {req, req};
    rot   = dbl[prio +: NREQ];
    valid = |rot;
    off   = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (rot[k-1]) off = idx_t'(k - 1);
    end
    idx = prio + off;
  end

endmodule

// File: rtl/jtsdram_rdarb.sv
// Round-robin read arbiter: four bank requesters share one SDRAM read
// channel. Holds the transaction FSM, latched address, fairness pointer
// and a watchdog that aborts stalled transactions.
module jtsdram_rdarb
  import jtsdram_rdarb_pkg::*;
#(
  parameter int unsigned AW     = 22,
  parameter int unsigned TOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ-1:0]     req_rd,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     req_rdy,
  output logic [AW-1:0]       sdram_addr,
  output logic [IDX_W-1:0]    sdram_ba,
  output logic                sdram_rd,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  output logic                busy,
  output logic                timeout
);

  state_t            state, state_nx;
  idx_t              grant, prio;
  logic [TOUT_W-1:0] cnt;
  logic              cnt_full;
  logic              pick_valid;
  idx_t              pick_idx;
  logic              launch, done, expire;

  jtsdram_rr_pick u_pick (
    .req   (req_rd),
    .prio  (prio),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign cnt_full = &cnt;
  assign busy     = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and combinational forwarding of ack/rdy to the granted requester.
  // A completing rdy takes precedence over a watchdog expiry in the same cycle.
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    done     = 1'b0;
    expire   = 1'b0;
    req_ack  = '0;
    req_rdy  = '0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          launch   = 1'b1;
          state_nx = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) req_ack = onehot(grant);
        if (sdram_ack && sdram_rdy) begin
          req_rdy  = onehot(grant);
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else if (cnt_full) begin
          expire   = 1'b1;
          state_nx = ST_IDLE;
        end else if (sdram_ack) begin
          state_nx = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (sdram_rdy) begin
          req_rdy  = onehot(grant);
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else if (cnt_full) begin
          expire   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Grant latch, command outputs, fairness pointer, watchdog and sticky timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      prio       <= '0;
      cnt        <= '0;
      sdram_addr <= '0;
      sdram_ba   <= '0;
      sdram_rd   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (launch) begin
        grant      <= pick_idx;
        sdram_ba   <= pick_idx;
        sdram_addr <= req_addr[32'(pick_idx)*AW +: AW];
        sdram_rd   <= 1'b1;
        cnt        <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
      if (state == ST_WAIT_ACK && sdram_ack) sdram_rd <= 1'b0;
      if (expire) begin
        sdram_rd <= 1'b0;
        timeout  <= 1'b1;
      end
      if (done || expire) prio <= next_idx(grant);
    end
  end

endmodule

// File: tb/tb_jtsdram_rdarb.sv
// Self-checking bench for jtsdram_rdarb: directed scenarios plus random
// traffic, compared each cycle against a transaction-level reference model.
module tb_jtsdram_rdarb;

  localparam int AW     = 22;
  localparam int TOUT_W = 4;
  localparam int TLIM   = (1 << TOUT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4*AW-1:0]  req_addr;
  logic [3:0]       req_rd;
  logic [3:0]       req_ack, req_rdy;
  logic [AW-1:0]    sdram_addr;
  logic [1:0]       sdram_ba;
  logic             sdram_rd, sdram_ack, sdram_rdy, busy, timeout;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: one outstanding transaction described by its attributes
  bit          m_active, m_acked, m_tout;
  logic [1:0]  m_grant, m_prio;
  logic [AW-1:0] m_addr;
  int          m_age;
  int          grants[$];

  jtsdram_rdarb #(.AW(AW), .TOUT_W(TOUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_addr   (req_addr),
    .req_rd     (req_rd),
    .req_ack    (req_ack),
    .req_rdy    (req_rdy),
    .sdram_addr (sdram_addr),
    .sdram_ba   (sdram_ba),
    .sdram_rd   (sdram_rd),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_acked = 0; m_tout = 0;
    m_grant = '0; m_prio = '0; m_addr = '0; m_age = 0;
  endtask

  task automatic model_advance();
    bit found;
    int r;
    if (!m_active) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        r = (int'(m_prio) + k) % 4;
        if (!found && req_rd[r]) begin
          found    = 1;
          m_active = 1;
          m_acked  = 0;
          m_grant  = 2'(r);
          m_addr   = req_addr[r*AW +: AW];
          m_age    = 0;
          grants.push_back(r);
        end
      end
    end else if (sdram_rdy && (m_acked || sdram_ack)) begin
      m_active = 0;
      m_prio   = 2'(m_grant + 2'd1);
    end else if (m_age == TLIM) begin
      m_tout   = 1;
      m_active = 0;
      m_prio   = 2'(m_grant + 2'd1);
    end else begin
      if (sdram_ack) m_acked = 1;
      m_age++;
    end
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic step();
    logic [3:0] e_ack, e_rdy;
    #1;
    if (rst) model_reset();
    e_ack = (m_active && !m_acked && sdram_ack) ? (4'b0001 << m_grant) : 4'b0000;
    e_rdy = (m_active && sdram_rdy && (m_acked || sdram_ack)) ? (4'b0001 << m_grant) : 4'b0000;
    chk("sdram_rd",   32'(sdram_rd),   32'(m_active && !m_acked));
    chk("sdram_addr", 32'(sdram_addr), 32'(m_addr));
    chk("sdram_ba",   32'(sdram_ba),   32'(m_grant));
    chk("busy",       32'(busy),       32'(m_active));
    chk("timeout",    32'(timeout),    32'(m_tout));
    chk("req_ack",    32'(req_ack),    32'(e_ack));
    chk("req_rdy",    32'(req_rdy),    32'(e_rdy));
    if (!rst) model_advance();
    @(negedge clk);
  endtask

  // Controller behaviour: 0 = ack/rdy 2 cycles apart, 1 = ack+rdy together, 2 = never rdy
  task automatic drive_ctl(input int mode);
    sdram_ack = 0;
    sdram_rdy = 0;
    case (mode)
      0: begin
        sdram_ack = m_active && !m_acked && m_age == 2;
        sdram_rdy = m_active && m_acked && m_age == 4;
      end
      1: begin
        sdram_ack = m_active && !m_acked && m_age == 1;
        sdram_rdy = sdram_ack;
      end
      default: sdram_ack = m_active && !m_acked && m_age == 1;
    endcase
  endtask

  task automatic rand_addr();
    req_addr = 88'({$urandom(), $urandom(), $urandom()});
  endtask

  initial begin
    int base, g, cyc, tg;
    int per[4];
    rst = 1; req_addr = '0; req_rd = '0; sdram_ack = 0; sdram_rdy = 0;
    model_reset();
    @(negedge clk);

    // reset values
    step();
    step();
    rst = 0;
    step();

    // single request from requester 2
    req_addr[2*AW +: AW] = 22'h12345;
    for (int t = 0; t < 10; t++) begin
      req_rd    = (t <= 6) ? 4'b0100 : 4'b0000;
      sdram_ack = (t == 4);
      sdram_rdy = (t == 6);
      if (t == 1) begin
        #1;
        chk("single_rd",   32'(sdram_rd),   32'd1);
        chk("single_ba",   32'(sdram_ba),   32'd2);
        chk("single_addr", 32'(sdram_addr), 32'h12345);
      end
      if (t == 4) begin #1; chk("single_ack", 32'(req_ack), 32'b0100); end
      if (t == 6) begin #1; chk("single_rdy", 32'(req_rdy), 32'b0100); end
      if (t == 7) begin #1; chk("single_busy_drop", 32'(busy), 32'd0); end
      step();
    end
    sdram_ack = 0; sdram_rdy = 0;

    // all four requesting continuously: strict rotation over 64 grants
    base = grants.size();
    req_rd = 4'b1111;
    cyc = 0;
    while (grants.size() < base + 64 && cyc < 2000) begin
      rand_addr();
      drive_ctl(0);
      step();
      cyc++;
    end
    chk("fair_grant_count", 32'(grants.size() - base), 32'd64);
    per = '{default: 0};
    for (int i = base; i < grants.size() && i < base + 64; i++) begin
      per[grants[i]]++;
      if (i > base) chk("rr_order", 32'(grants[i]), 32'((grants[i-1] + 1) % 4));
    end
    for (int i = 0; i < 4; i++) chk("fair_share", 32'(per[i]), 32'd16);

    // ack and rdy in the same cycle
    for (int t = 0; t < 20; t++) begin
      drive_ctl(1);
      step();
    end

    // watchdog: ack but never rdy
    cyc = 0;
    while (!m_tout && cyc < 100) begin
      drive_ctl(2);
      step();
      cyc++;
    end
    chk("timeout_reached", 32'(m_tout), 32'd1);
    tg = grants[$];
    base = grants.size();
    cyc = 0;
    while (grants.size() == base && cyc < 20) begin
      drive_ctl(0);
      step();
      cyc++;
    end
    chk("after_timeout_grant", 32'(grants[$]), 32'((tg + 1) % 4));

    // reset while waiting for rdy, rdy arriving after release
    cyc = 0;
    while (!(m_active && m_acked) && cyc < 40) begin
      drive_ctl(0);
      step();
      cyc++;
    end
    chk("reached_wait_rdy", 32'(m_active && m_acked), 32'd1);
    sdram_ack = 0; sdram_rdy = 0;
    rst = 1;
    step();
    step();
    rst = 0;
    sdram_rdy = 1;
    base = grants.size();
    step();
    sdram_rdy = 0;
    chk("post_reset_grant", 32'(grants[$]), 32'd0);
    chk("post_reset_new", 32'(grants.size() - base), 32'd1);

    // drain, then requester 1 drops req_rd after grant
    req_rd = 4'b0000;
    cyc = 0;
    while (m_active && cyc < 40) begin drive_ctl(0); step(); cyc++; end
    req_rd = 4'b0010;
    step();
    chk("drop_granted", 32'(m_grant), 32'd1);
    req_rd = 4'b0000;
    cyc = 0;
    g = 0;
    while (m_active && cyc < 40) begin
      drive_ctl(0);
      if (sdram_rdy) begin #1; chk("drop_rdy", 32'(req_rdy), 32'b0010); g++; end
      step();
      cyc++;
    end
    chk("drop_completed", 32'(g), 32'd1);

    // random traffic including ack/rdy noise while idle
    for (int t = 0; t < 600; t++) begin
      req_rd    = 4'($urandom);
      rand_addr();
      sdram_ack = ($urandom_range(0, 2) == 0);
      sdram_rdy = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
